// File: rtl/mbus_mem_responder.sv
// mbus_mem_responder: mbus memory target with queued in-order reads, byte-strobed writes and a write-response queue
module mbus_mem_responder #(
   parameter int                           MBUS_ADDR_WIDTH = 32,
   parameter int                           MBUS_DATA_WIDTH = 32,
   parameter int                           MBUS_DW_B       = MBUS_DATA_WIDTH / 8,
   parameter int                           MEM_DEPTH_BITS  = 12,
   parameter logic [MBUS_ADDR_WIDTH-1:0]   BASE_ADDR       = '0,
   parameter int                           READ_LATENCY    = 2,
   parameter int                           RQ_DEPTH_BITS   = 2,
   parameter int                           BQ_DEPTH_BITS   = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [MBUS_ADDR_WIDTH-1:0] mbus_ar_addr,
   input  logic                       mbus_ar_valid,
   output logic                       mbus_ar_ready,
   output logic [MBUS_DATA_WIDTH-1:0] mbus_r_data,
   output logic                       mbus_r_valid,
   input  logic                       mbus_r_ready,
   input  logic [MBUS_ADDR_WIDTH-1:0] mbus_aw_addr,
   input  logic                       mbus_aw_valid,
   output logic                       mbus_aw_ready,
   input  logic [MBUS_DATA_WIDTH-1:0] mbus_w_data,
   input  logic                       mbus_w_valid,
   input  logic [MBUS_DW_B-1:0]       mbus_w_strb,
   output logic                       mbus_b_resp,
   output logic                       mbus_b_valid,
   input  logic                       mbus_b_ready,
   input  logic                       ar_stall,
   input  logic                       aw_stall,
   output logic [RQ_DEPTH_BITS+1:0]   rd_outstanding
);
   localparam int OFF_LSB = $clog2(MBUS_DW_B);
   localparam int CNT_W   = $clog2(READ_LATENCY + 1);
   localparam logic [MBUS_ADDR_WIDTH:0] MEM_BYTES = (MBUS_ADDR_WIDTH+1)'(MBUS_DW_B) << MEM_DEPTH_BITS;
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;

   logic [MBUS_DATA_WIDTH-1:0] mem_q [2**MEM_DEPTH_BITS];

   logic [MBUS_ADDR_WIDTH-1:0] rq_mem_q [2**RQ_DEPTH_BITS];
   logic [RQ_DEPTH_BITS-1:0]   rq_wr_q, rq_rd_q;
   logic [RQ_DEPTH_BITS:0]     rq_cnt_q;
   logic                       rq_push, rq_pop, rq_empty;

   logic                       bq_mem_q [2**BQ_DEPTH_BITS];
   logic [BQ_DEPTH_BITS-1:0]   bq_wr_q, bq_rd_q;
   logic [BQ_DEPTH_BITS:0]     bq_cnt_q;
   logic                       bq_push, bq_pop;

   rstate_e                    state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [MBUS_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [MBUS_DATA_WIDTH-1:0] r_data_q, r_data_d;

   logic [MBUS_ADDR_WIDTH-1:0] rd_off, wr_off;
   logic                       rd_in, wr_in;

   assign rd_off = rd_addr_q - BASE_ADDR;
   assign wr_off = mbus_aw_addr - BASE_ADDR;
   assign rd_in  = {1'b0, rd_off} < MEM_BYTES;
   assign wr_in  = {1'b0, wr_off} < MEM_BYTES;

   assign mbus_ar_ready  = rst_n & ~ar_stall & ~rq_cnt_q[RQ_DEPTH_BITS];
   assign rq_push        = mbus_ar_valid & mbus_ar_ready;
   assign rq_empty       = rq_cnt_q == '0;
   assign mbus_r_valid   = state_q == R_RESP;
   assign mbus_r_data    = r_data_q;
   assign rd_outstanding = {1'b0, rq_cnt_q} + (RQ_DEPTH_BITS+2)'(state_q != R_IDLE);

   assign mbus_aw_ready = rst_n & ~aw_stall & ~bq_cnt_q[BQ_DEPTH_BITS];
   assign bq_push       = mbus_aw_valid & mbus_w_valid & mbus_aw_ready;
   assign mbus_b_valid  = bq_cnt_q != '0;
   assign mbus_b_resp   = mbus_b_valid & bq_mem_q[bq_rd_q];
   assign bq_pop        = mbus_b_valid & mbus_b_ready;

   // read-address queue: circular buffer, count MSB doubles as the full flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rq_wr_q  <= '0;
         rq_rd_q  <= '0;
         rq_cnt_q <= '0;
      end else begin
         if (rq_push) begin
            rq_mem_q[rq_wr_q] <= mbus_ar_addr;
            rq_wr_q           <= rq_wr_q + 1'b1;
         end
         if (rq_pop) rq_rd_q <= rq_rd_q + 1'b1;
         rq_cnt_q <= rq_cnt_q + (RQ_DEPTH_BITS+1)'(rq_push) - (RQ_DEPTH_BITS+1)'(rq_pop);
      end
   end

   // write-response queue: one error bit per accepted write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bq_wr_q  <= '0;
         bq_rd_q  <= '0;
         bq_cnt_q <= '0;
      end else begin
         if (bq_push) begin
            bq_mem_q[bq_wr_q] <= ~wr_in;
            bq_wr_q           <= bq_wr_q + 1'b1;
         end
         if (bq_pop) bq_rd_q <= bq_rd_q + 1'b1;
         bq_cnt_q <= bq_cnt_q + (BQ_DEPTH_BITS+1)'(bq_push) - (BQ_DEPTH_BITS+1)'(bq_pop);
      end
   end

   // RAM write port: byte-strobed, out-of-range writes leave the RAM untouched
   always_ff @(posedge clk) begin
      if (bq_push && wr_in)
         for (int i = 0; i < MBUS_DW_B; i++)
            if (mbus_w_strb[i]) mem_q[wr_off[OFF_LSB +: MEM_DEPTH_BITS]][8*i +: 8] <= mbus_w_data[8*i +: 8];
   end

   // read FSM state and response registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= R_IDLE;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         r_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         r_data_q  <= r_data_d;
      end
   end

   // read FSM next state: pop, count down the latency, sample RAM, hold response until taken
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_addr_d = rd_addr_q;
      r_data_d  = r_data_q;
      rq_pop    = 1'b0;
      case (state_q)
         R_IDLE: begin
            if (!rq_empty) begin
               rq_pop    = 1'b1;
               cnt_d     = LAT_M1;
               rd_addr_d = rq_mem_q[rq_rd_q];
               state_d   = R_WAIT;
            end
         end
         R_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               r_data_d = rd_in ? mem_q[rd_off[OFF_LSB +: MEM_DEPTH_BITS]] : '0;
               state_d  = R_RESP;
            end
         end
         R_RESP: begin
            if (mbus_r_ready) begin
               if (!rq_empty) begin
                  rq_pop    = 1'b1;
                  cnt_d     = LAT_M1;
                  rd_addr_d = rq_mem_q[rq_rd_q];
                  state_d   = R_WAIT;
               end else begin
                  state_d = R_IDLE;
               end
            end
         end
         default: state_d = R_IDLE;
      endcase
   end
endmodule

// File: tb/tb_mbus_mem_responder.sv
// tb_mbus_mem_responder: directed self-checking bench for mbus_mem_responder
module tb_mbus_mem_responder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ar_addr, aw_addr, w_data, r_data;
   logic        ar_valid, ar_ready, r_valid, r_ready;
   logic        aw_valid, aw_ready, w_valid, b_resp, b_valid, b_ready;
   logic [3:0]  w_strb;
   logic        ar_stall, aw_stall;
   logic [3:0]  rd_outstanding;
   int          n_tests = 0;
   int          n_fail = 0;

   mbus_mem_responder dut (
      .clk(clk), .rst_n(rst_n),
      .mbus_ar_addr(ar_addr), .mbus_ar_valid(ar_valid), .mbus_ar_ready(ar_ready),
      .mbus_r_data(r_data), .mbus_r_valid(r_valid), .mbus_r_ready(r_ready),
      .mbus_aw_addr(aw_addr), .mbus_aw_valid(aw_valid), .mbus_aw_ready(aw_ready),
      .mbus_w_data(w_data), .mbus_w_valid(w_valid), .mbus_w_strb(w_strb),
      .mbus_b_resp(b_resp), .mbus_b_valid(b_valid), .mbus_b_ready(b_ready),
      .ar_stall(ar_stall), .aw_stall(aw_stall), .rd_outstanding(rd_outstanding)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic exp_resp);
      aw_addr = a; w_data = d; w_strb = s; aw_valid = 1; w_valid = 1; b_ready = 1;
      for (int c = 0; c < 20 && !aw_ready; c++) tick;
      tick;
      aw_valid = 0; w_valid = 0;
      check({tag, "_bvalid"}, 32'(b_valid), 1);
      check({tag, "_bresp"}, 32'(b_resp), 32'(exp_resp));
      tick;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
      ar_addr = a; ar_valid = 1; r_ready = 0;
      for (int c = 0; c < 20 && !ar_ready; c++) tick;
      tick;
      ar_valid = 0;
      lat = 1;
      while (!r_valid && lat < 40) begin
         tick;
         lat++;
      end
      d = r_data;
      r_ready = 1;
      tick;
      r_ready = 0;
   endtask

   initial begin
      logic [31:0] d;
      int          lat, acc, got;
      logic        pend;
      rst_n = 0; ar_addr = 0; ar_valid = 0; r_ready = 0;
      aw_addr = 0; aw_valid = 0; w_data = 0; w_valid = 0; w_strb = 0; b_ready = 0;
      ar_stall = 0; aw_stall = 0;
      tick; tick;
      check("rst_rvalid", 32'(r_valid), 0);
      check("rst_rdata", r_data, 0);
      check("rst_bvalid", 32'(b_valid), 0);
      check("rst_bresp", 32'(b_resp), 0);
      check("rst_outstanding", 32'(rd_outstanding), 0);
      rst_n = 1;
      tick;
      check("idle_ar_ready", 32'(ar_ready), 1);
      check("idle_aw_ready", 32'(aw_ready), 1);

      do_write("t1_wr", 32'h10, 32'hCAFEF00D, 4'hF, 0);
      check("t1_bvalid_drop", 32'(b_valid), 0);
      do_read(32'h10, d, lat);
      check("t1_latency", 32'(lat), 4);
      check("t1_rdata", d, 32'hCAFEF00D);
      check("t1_rvalid_drop", 32'(r_valid), 0);

      do_write("t2_wr_a", 32'h20, 32'hFFFFFFFF, 4'hF, 0);
      do_write("t2_wr_b", 32'h20, 32'h00000000, 4'b0101, 0);
      do_read(32'h20, d, lat);
      check("t2_rdata", d, 32'hFF00FF00);

      do_write("t3_wr0", 32'h0, 32'h12345678, 4'hF, 0);
      do_write("t3_wr_oor", 32'h4000, 32'hDEADBEEF, 4'hF, 1);
      do_read(32'h0, d, lat);
      check("t3_ram_kept", d, 32'h12345678);
      do_read(32'h4000, d, lat);
      check("t3_oor_rdata", d, 0);

      for (int i = 0; i < 6; i++) do_write("t4_fill", 32'(4 * i), 32'hA5A50000 + 32'(i), 4'hF, 0);
      r_ready = 0; acc = 0;
      for (int i = 0; i < 6; i++) begin
         ar_addr = 32'(4 * acc); ar_valid = 1;
         if (!ar_ready) break;
         tick;
         acc++;
      end
      ar_addr = 32'(4 * acc);
      tick;
      check("t4_accepted", 32'(acc), 5);
      check("t4_ar_ready_low", 32'(ar_ready), 0);
      check("t4_outstanding5", 32'(rd_outstanding), 5);
      r_ready = 1; got = 0; pend = 0;
      for (int c = 0; c < 100 && got < 6; c++) begin
         pend = ar_valid & ar_ready;
         if (r_valid) begin
            check($sformatf("t4_rdata%0d", got), r_data, 32'hA5A50000 + 32'(got));
            got++;
         end
         tick;
         if (pend) ar_valid = 0;
      end
      r_ready = 0; ar_valid = 0;
      check("t4_responses", 32'(got), 6);
      tick;
      check("t4_outstanding0", 32'(rd_outstanding), 0);

      b_ready = 0; acc = 0;
      for (int i = 0; i < 5; i++) begin
         aw_addr = 32'h100 + 32'(4 * acc); w_data = 32'(i); w_strb = 4'hF;
         aw_valid = 1; w_valid = 1;
         if (!aw_ready) break;
         tick;
         acc++;
      end
      check("t5_accepted4", 32'(acc), 4);
      check("t5_aw_ready_low", 32'(aw_ready), 0);
      b_ready = 1;
      tick;
      b_ready = 0;
      for (int c = 0; c < 5; c++) begin
         aw_addr = 32'h100 + 32'(4 * acc);
         if (aw_ready) acc++;
         tick;
      end
      aw_valid = 0; w_valid = 0;
      check("t5_accepted5", 32'(acc), 5);
      b_ready = 1; got = 0;
      for (int c = 0; c < 20; c++) begin
         if (b_valid) begin
            got++;
            check("t5_bresp", 32'(b_resp), 0);
         end
         tick;
      end
      b_ready = 0;
      check("t5_drained", 32'(got), 4);

      r_ready = 0;
      ar_valid = 1;
      ar_addr = 32'h0; tick;
      ar_addr = 32'h4; tick;
      ar_addr = 32'h8; tick;
      ar_valid = 0;
      check("t6_pre_outstanding", 32'(rd_outstanding), 3);
      rst_n = 0;
      tick;
      check("t6_rvalid", 32'(r_valid), 0);
      check("t6_outstanding", 32'(rd_outstanding), 0);
      rst_n = 1;
      tick;
      for (int c = 0; c < 6; c++) begin
         check("t6_no_stale_rvalid", 32'(r_valid), 0);
         tick;
      end
      do_read(32'h20, d, lat);
      check("t6_ram_kept_20", d, 32'hFF00FF00);
      do_read(32'h8, d, lat);
      check("t6_ram_kept_08", d, 32'hA5A50002);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
